// File: rtl/ram_pkg.sv
// Shared types and constants for the parameterised single-port RAM.
// Holds the fill FSM state encoding and the legal read-latency values.
package ram_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  localparam int unsigned RDLAT_ONE = 1;
  localparam int unsigned RDLAT_TWO = 2;

  function automatic int unsigned num_lanes(int unsigned wid, int unsigned bytew);
    return wid / bytew;
  endfunction

endpackage

// File: rtl/ram_clr_seq.sv
// Zero-fill sequencer: walks every word address once after reset or clr,
// then parks in READY until the next clr.
module ram_clr_seq
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AWID  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  output logic            busy,
  output logic            fill_we,
  output logic [AWID-1:0] fill_addr
);

  localparam logic [AWID-1:0] LastAddr = AWID'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [AWID-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      if (cnt_q == LastAddr) begin
        state_d = READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AWID'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    busy      = (state_q == CLEAR);
    fill_we   = (state_q == CLEAR);
    fill_addr = cnt_q;
  end

endmodule

// File: rtl/ram_sp_param.sv
// Single-port RAM with per-lane write mask, zero-fill on reset/clr,
// 1- or 2-cycle read latency and a registered error pulse.
module ram_sp_param
  import ram_pkg::*;
#(
  parameter int unsigned WID   = 16,
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AWID  = $clog2(DEPTH),
  parameter int unsigned BYTEW = 8,
  parameter int unsigned RDLAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cen,
  input  logic                 wen,
  input  logic [WID/BYTEW-1:0] ben,
  input  logic [AWID-1:0]      addr,
  input  logic [WID-1:0]       din,
  input  logic                 clr,
  output logic [WID-1:0]       dout,
  output logic                 dout_vld,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned NLane = num_lanes(WID, BYTEW);

  logic [WID-1:0] mem [DEPTH];

  logic            fill_we;
  logic [AWID-1:0] fill_addr;

  ram_clr_seq #(
    .DEPTH (DEPTH),
    .AWID  (AWID)
  ) u_clr_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .busy      (busy),
    .fill_we   (fill_we),
    .fill_addr (fill_addr)
  );

  logic           ctl_x;
  logic           in_range;
  logic           acc;
  logic           blocked;
  logic           wr_en;
  logic           rd_en;
  logic           err_d;
  logic [WID-1:0] rd_data;

  // Unknown control is only meaningful in 4-state simulation; hardware sees 0.
  always_comb begin
    ctl_x    = (cen !== 1'b1) && $isunknown({cen, wen, ben, addr});
    in_range = (32'(addr) < DEPTH);
    acc      = (cen == 1'b0) && !ctl_x;
    blocked  = busy || clr;
    wr_en    = acc && !blocked && !wen && in_range;
    rd_en    = !blocked && ((acc && wen) || (ctl_x && (wen !== 1'b0)));
    err_d    = (acc && (blocked || !in_range)) || ctl_x;
  end

  always_comb begin
    rd_data = '0;
    if (ctl_x) begin
      rd_data = 'x;
    end else if (in_range) begin
      rd_data = mem[addr];
    end
  end

  // No reset on the array: contents are cleared only by the fill walk.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem[fill_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NLane; i++) begin
        if (!ben[i]) begin
          mem[addr][i*BYTEW +: BYTEW] <= din[i*BYTEW +: BYTEW];
        end
      end
    end
  end

  logic           vld1_q;
  logic [WID-1:0] data1_q;
  logic           err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      data1_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld1_q <= rd_en;
      err_q  <= err_d;
      if (rd_en) begin
        data1_q <= rd_data;
      end
    end
  end

  always_comb err = err_q;

  if (RDLAT == RDLAT_TWO) begin : g_lat2
    logic           vld2_q;
    logic [WID-1:0] data2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld2_q  <= 1'b0;
        data2_q <= '0;
      end else begin
        vld2_q <= vld1_q;
        if (vld1_q) begin
          data2_q <= data1_q;
        end
      end
    end

    always_comb begin
      dout     = data2_q;
      dout_vld = vld2_q;
    end
  end else begin : g_lat1
    always_comb begin
      dout     = data1_q;
      dout_vld = vld1_q;
    end
  end

endmodule

// File: doc/ram_sp_param.md
RAM_SP_PARAM -- requirements
Module: ram_sp_param

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low; the ports SHALL be named clk and rst_n.
REQ-002 Parameter WID, default 16: data width in bits; SHALL be a multiple of BYTEW.
REQ-003 Parameter DEPTH, default 512: number of words; need not be a power of 2.
REQ-004 Parameter AWID, default $clog2(DEPTH): address width.
REQ-005 Parameter BYTEW, default 8: bits per write-enable lane.
REQ-006 Parameter RDLAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 cen  in  1  chip enable, active-low.
REQ-010 wen  in  1  write enable, active-low; 1 with cen=0 means read.
REQ-011 ben  in  WID/BYTEW  per-lane write mask, active-low; 0 means write that lane.
REQ-012 addr  in  AWID  word address.
REQ-013 din  in  WID  write data.
REQ-014 clr  in  1  one-cycle pulse that restarts the zero-fill sequence.
REQ-015 dout  out  WID  read data.
REQ-016 dout_vld  out  1  one-cycle pulse marking valid dout.
REQ-017 busy  out  1  high while the zero-fill sequence runs.
REQ-018 err  out  1  one-cycle pulse on a rejected access.

Function
REQ-019 The FSM SHALL have two states: CLEAR and READY. Reset enters CLEAR with the fill counter at 0; clr in any state also enters CLEAR with the counter at 0.
REQ-020 In CLEAR the block SHALL write all-zero data to mem[counter] once per cycle and increment the counter; after writing DEPTH-1 it SHALL go to READY. The fill takes exactly DEPTH cycles, and busy=1 throughout.
REQ-021 While busy=1, any cen=0 access SHALL be dropped, with err=1 in the following cycle.
REQ-022 If clr and cen=0 occur in the same cycle, clr SHALL win, the access SHALL be dropped and err SHALL pulse.
REQ-023 On a write (READY, cen=0, wen=0), only lanes with ben[i]=0 SHALL be updated; all other lanes SHALL be unchanged.
REQ-024 On a read (READY, cen=0, wen=1), mem[addr] SHALL appear on dout, with dout_vld=1, RDLAT cycles after the sampling edge.
REQ-025 With RDLAT=2, an extra output register SHALL be added, and back-to-back reads SHALL sustain one result per cycle.
REQ-026 dout SHALL hold its last valid value between reads; the block SHALL NOT drive X on idle cycles.
REQ-027 A read of an address written in the previous cycle SHALL return the new data.
REQ-028 Out-of-range addresses (addr >= DEPTH) SHALL be handled as follows: writes are ignored; reads return 0 with dout_vld=1; err pulses 1 cycle after sampling.
REQ-029 An X/Z value on cen, wen, ben or addr with cen not 1 (simulation only) SHALL cause no write and an err pulse; a read in that case SHALL return all-X.
REQ-030 err SHALL be registered, asserted 1 cycle after the offending edge, and independent of RDLAT.

Reset
REQ-031 Under rst_n=0, the outputs SHALL be: dout=0, dout_vld=0, err=0, busy=1, state=CLEAR, counter=0.
REQ-032 Asserting rst_n mid-fill or mid-read SHALL abort the operation; the fill SHALL restart from address 0 after release.
REQ-033 Memory contents SHALL be cleared only by the fill sequence, not by rst_n directly.

Structure
REQ-034 The shared package ram_pkg SHALL hold the state enum (CLEAR, READY) and the RDLAT legal-value constants.
REQ-035 The fill FSM and counter SHALL be a single sub-module named ram_clr_seq, with outputs busy, fill_we and fill_addr.

Verification (WID=16, DEPTH=512, BYTEW=8)
REQ-036 Reset release: busy=1 for exactly 512 cycles, then 0; a read of 0x1FF then returns 0x0000, dout_vld after 1 cycle.
REQ-037 Write 0xABCD to 0x010 with ben=2'b00, then write 0x1234 with ben=2'b10; a read SHALL return 0xAB34.
REQ-038 With RDLAT=2, three back-to-back reads of 0x000, 0x001, 0x002 SHALL give dout_vld high for 3 consecutive cycles starting 2 cycles after the first read.
REQ-039 With DEPTH=500, a write to address 0x1F4 SHALL NOT alter memory, a read of 0x1F4 SHALL return 0x0000, and each access SHALL pulse err.
REQ-040 clr pulsed at the same edge as a write of 0x5555 to 0x003: err pulses, busy is high for 512 cycles, and a later read of 0x003 returns 0x0000.
REQ-041 rst_n asserted at fill count 100 and released: busy SHALL be high for a full 512 cycles after release.
